// File: rtl/tmds_word_aligner_pkg.sv
// tmds_word_aligner_pkg: control tokens, lock states and shared helpers for the TMDS word aligner
package tmds_word_aligner_pkg;
    localparam int SLIP_W = 4;
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} align_state_t;

    function automatic logic is_ctrl(input logic [9:0] w);
        return (w == CTRL_00) || (w == CTRL_01) || (w == CTRL_10) || (w == CTRL_11);
    endfunction
endpackage

// File: rtl/tmds_word_aligner_ch.sv
// tmds_word_aligner_ch: bit-slip word aligner and lock FSM for one TMDS channel
module tmds_word_aligner_ch
    import tmds_word_aligner_pkg::*;
#(
    parameter int BITS         = 10,
    parameter int TIMEOUT      = 2**18,
    parameter int LOCK_MATCHES = 4,
    parameter int AUTO_SLIP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BITS-1:0]   in_data,
    input  logic              slip_req,
    output logic [BITS-1:0]   out_data,
    output logic              out_ctrl,
    output logic              locked,
    output logic [SLIP_W-1:0] slip
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(LOCK_MATCHES + 1);

    logic [BITS-1:0]   prev;
    logic [2*BITS-1:0] win;
    logic [BITS-1:0]   cand;
    logic              match;
    logic              expire;
    logic              last_hit;
    logic [SLIP_W-1:0] slip_inc;
    logic [SLIP_W-1:0] slip_nx;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nx;
    logic [HW-1:0]     hits;
    logic [HW-1:0]     hits_nx;
    align_state_t      state;
    align_state_t      state_nx;

    // prev holds the earlier word, so it sits in the low (earliest) bits of the window
    assign win      = {in_data, prev};
    assign cand     = BITS'(win >> slip);
    assign match    = is_ctrl(cand);
    assign expire   = timer == TW'(TIMEOUT - 1);
    assign last_hit = hits == HW'(LOCK_MATCHES - 1);
    assign slip_inc = (slip == SLIP_W'(BITS - 1)) ? '0 : slip + SLIP_W'(1);
    assign locked   = state == LOCKED;

    // next state: invalid input forces HUNT, then slip request, token match, timeout in that order
    always_comb begin
        state_nx = state;
        slip_nx  = slip;
        hits_nx  = hits;
        timer_nx = timer + TW'(1);
        if (!in_valid) begin
            state_nx = HUNT;
            hits_nx  = '0;
            timer_nx = '0;
        end else if (state == HUNT && slip_req) begin
            slip_nx  = slip_inc;
            hits_nx  = '0;
            timer_nx = '0;
        end else if (match) begin
            timer_nx = '0;
            if (state == HUNT) begin
                hits_nx  = last_hit ? '0 : hits + HW'(1);
                state_nx = last_hit ? LOCKED : HUNT;
            end
        end else if (expire) begin
            state_nx = HUNT;
            hits_nx  = '0;
            timer_nx = '0;
            if (AUTO_SLIP != 0) slip_nx = slip_inc;
        end
    end

    // state registers plus the registered aligned word; out_data holds while input is invalid
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            slip     <= '0;
            hits     <= '0;
            timer    <= '0;
            prev     <= '0;
            out_data <= '0;
            out_ctrl <= 1'b0;
        end else begin
            state    <= state_nx;
            slip     <= slip_nx;
            hits     <= hits_nx;
            timer    <= timer_nx;
            prev     <= in_valid ? in_data : prev;
            out_data <= in_valid ? cand : out_data;
            out_ctrl <= in_valid && match;
        end
    end
endmodule

// File: rtl/tmds_word_aligner.sv
// tmds_word_aligner: independent per-channel TMDS bit-slip alignment with a combined lock flag
module tmds_word_aligner
    import tmds_word_aligner_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int BITS         = 10,
    parameter int TIMEOUT      = 2**18,
    parameter int LOCK_MATCHES = 4,
    parameter int AUTO_SLIP    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NUM_CH*BITS-1:0]   in_data,
    input  logic [NUM_CH-1:0]        slip_req,
    output logic [NUM_CH*BITS-1:0]   out_data,
    output logic [NUM_CH-1:0]        out_ctrl,
    output logic [NUM_CH-1:0]        locked,
    output logic                     all_locked,
    output logic [NUM_CH*SLIP_W-1:0] slip
);
    genvar c;
    for (c = 0; c < NUM_CH; c++) begin : g_ch
        tmds_word_aligner_ch #(
            .BITS(BITS),
            .TIMEOUT(TIMEOUT),
            .LOCK_MATCHES(LOCK_MATCHES),
            .AUTO_SLIP(AUTO_SLIP)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .in_valid(in_valid),
            .in_data(in_data[c*BITS +: BITS]),
            .slip_req(slip_req[c]),
            .out_data(out_data[c*BITS +: BITS]),
            .out_ctrl(out_ctrl[c]),
            .locked(locked[c]),
            .slip(slip[c*SLIP_W +: SLIP_W])
        );
    end

    // combined lock flag, one cycle behind the per-channel flags
    always_ff @(posedge clk) begin
        if (reset) all_locked <= 1'b0;
        else all_locked <= &locked;
    end
endmodule

// File: tb/tb_tmds_word_aligner.sv
// tb_tmds_word_aligner: directed and randomized checks of the TMDS word aligner against a behavioural model
module tb_tmds_word_aligner;
    localparam int NC = 3;
    localparam int TO = 64;
    localparam int LM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        in_valid = 1'b1;
    logic [29:0] in_data = '0;
    logic [2:0]  slip_req_a = '0, slip_req_m = '0;
    logic [29:0] od_a, od_m;
    logic [2:0]  oc_a, oc_m, lk_a, lk_m;
    logic        al_a, al_m;
    logic [11:0] sl_a, sl_m;

    tmds_word_aligner #(.NUM_CH(NC), .BITS(10), .TIMEOUT(TO), .LOCK_MATCHES(LM), .AUTO_SLIP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .slip_req(slip_req_a),
        .out_data(od_a), .out_ctrl(oc_a), .locked(lk_a), .all_locked(al_a), .slip(sl_a)
    );

    tmds_word_aligner #(.NUM_CH(NC), .BITS(10), .TIMEOUT(TO), .LOCK_MATCHES(LM), .AUTO_SLIP(0)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .slip_req(slip_req_m),
        .out_data(od_m), .out_ctrl(oc_m), .locked(lk_m), .all_locked(al_m), .slip(sl_m)
    );

    int toks[4] = '{'h354, 'h0AB, 'h154, 'h2AB};
    int rot[NC];
    int tx_prev[NC];
    int cyc = 0;
    int tok_period = 16;
    bit tok_en = 1'b1;

    int s_slip[2][NC], s_hits[2][NC], s_timer[2][NC], s_out[2][NC], s_prev[2][NC];
    bit s_lock[2][NC], s_ctrl[2][NC], s_all[2];

    int checks = 0;
    int errors = 0;

    function automatic bit is_tok(int w);
        return w == 'h354 || w == 'h0AB || w == 'h154 || w == 'h2AB;
    endfunction

    // filler words keep bit pairs (0,1), (2,3), (7,8,9) equal, so no rotation of the
    // stream forms a token except at a true token position
    function automatic int filler();
        int w = int'($urandom_range(0, 1023)) & ~(2 | 8 | 256 | 512);
        if ((w & 1) != 0) w |= 2;
        if ((w & 4) != 0) w |= 8;
        if ((w & 128) != 0) w |= 256 | 512;
        return w;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(int i, bit auto_s, logic [2:0] sreq, int raw[NC]);
        bit all_now = 1'b1;
        for (int c = 0; c < NC; c++) all_now &= s_lock[i][c];
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                s_slip[i][c] = 0; s_hits[i][c] = 0; s_timer[i][c] = 0;
                s_out[i][c] = 0; s_prev[i][c] = 0; s_lock[i][c] = 0; s_ctrl[i][c] = 0;
            end
            s_all[i] = 1'b0;
            return;
        end
        s_all[i] = all_now;
        for (int c = 0; c < NC; c++) begin
            int cand = (((raw[c] << 10) | s_prev[i][c]) >> s_slip[i][c]) & 1023;
            bit hit = is_tok(cand);
            bit expired = s_timer[i][c] == TO - 1;
            int nxt = (s_slip[i][c] + 1) % 10;
            if (!in_valid) begin
                s_lock[i][c] = 0; s_hits[i][c] = 0; s_timer[i][c] = 0; s_ctrl[i][c] = 0;
                continue;
            end
            s_out[i][c] = cand;
            s_ctrl[i][c] = hit;
            s_prev[i][c] = raw[c];
            if (!s_lock[i][c] && sreq[c]) begin
                s_slip[i][c] = nxt; s_hits[i][c] = 0; s_timer[i][c] = 0;
            end else if (hit) begin
                s_timer[i][c] = 0;
                if (!s_lock[i][c]) begin
                    s_hits[i][c]++;
                    if (s_hits[i][c] == LM) begin
                        s_lock[i][c] = 1; s_hits[i][c] = 0;
                    end
                end
            end else if (expired) begin
                s_timer[i][c] = 0; s_hits[i][c] = 0; s_lock[i][c] = 0;
                if (auto_s) s_slip[i][c] = nxt;
            end else begin
                s_timer[i][c]++;
            end
        end
    endtask

    task automatic compare(int i, string n, logic [29:0] od, logic [2:0] oc, logic [2:0] lk,
                           logic al, logic [11:0] sl);
        logic [29:0] eo;
        logic [2:0]  ec, el;
        logic [11:0] es;
        for (int c = 0; c < NC; c++) begin
            eo[c*10 +: 10] = 10'(s_out[i][c]);
            ec[c] = s_ctrl[i][c];
            el[c] = s_lock[i][c];
            es[c*4 +: 4] = 4'(s_slip[i][c]);
        end
        check({n, "_out_data"}, 32'(od), 32'(eo));
        check({n, "_out_ctrl"}, 32'(oc), 32'(ec));
        check({n, "_locked"}, 32'(lk), 32'(el));
        check({n, "_all_locked"}, 32'(al), 32'(s_all[i]));
        check({n, "_slip"}, 32'(sl), 32'(es));
    endtask

    // one clock: build raw rotated words from a token/filler stream, advance model, compare
    task automatic step();
        int raw[NC];
        for (int c = 0; c < NC; c++) begin
            int t = (tok_en && cyc % tok_period == 0) ? toks[$urandom_range(0, 3)] : filler();
            raw[c] = (((t << 10) | tx_prev[c]) >> ((10 - rot[c]) % 10)) & 1023;
            tx_prev[c] = t;
            in_data[c*10 +: 10] = 10'(raw[c]);
        end
        cyc++;
        model_update(0, 1'b1, slip_req_a, raw);
        model_update(1, 1'b0, slip_req_m, raw);
        @(posedge clk);
        #1;
        compare(0, "a", od_a, oc_a, lk_a, al_a, sl_a);
        compare(1, "m", od_m, oc_m, lk_m, al_m, sl_m);
        slip_req_a = '0;
        slip_req_m = '0;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic set_rot(int r0, int r1, int r2);
        rot[0] = r0; rot[1] = r1; rot[2] = r2;
    endtask

    initial begin
        int k;
        for (int c = 0; c < NC; c++) tx_prev[c] = 0;
        // 1: rotation 3, sparse tokens -> slip hunts to 3 and locks
        set_rot(3, 3, 3);
        do_reset();
        check("rst_out_data", 32'(od_a), 32'h0);
        check("rst_locked", 32'(lk_a), 32'h0);
        check("rst_slip", 32'(sl_a), 32'h0);
        run(400);
        check("t1_slip", 32'(sl_a), 32'h333);
        check("t1_locked", 32'(lk_a), 32'h7);
        for (k = 0; k < 20 && !oc_a[0]; k++) step();
        check("t1_aligned_token", 32'(is_tok(int'(od_a[9:0]))), 32'h1);
        // 2: per-channel rotations 0/5/9, all_locked one cycle after the last lock
        set_rot(0, 5, 9);
        do_reset();
        for (k = 0; k < 900 && lk_a != 3'b111; k++) step();
        check("t2_locked", 32'(lk_a), 32'h7);
        check("t2_all_lag", 32'(al_a), 32'h0);
        check("t2_slip", 32'(sl_a), 32'h950);
        step();
        check("t2_all_locked", 32'(al_a), 32'h1);
        // 3: tokens stop -> unlock and exactly one slip advance, 9 wraps to 0
        tok_en = 1'b0;
        run(70);
        check("t3_unlocked", 32'(lk_a), 32'h0);
        check("t3_slip", 32'(sl_a), 32'h061);
        tok_en = 1'b1;
        // 4: manual slip on the AUTO_SLIP=0 instance
        set_rot(2, 2, 2);
        do_reset();
        slip_req_m = 3'b111;
        step();
        run(30);
        check("t4_slip1", 32'(sl_m), 32'h111);
        check("t4_nolock_slip1", 32'(lk_m), 32'h0);
        slip_req_m = 3'b111;
        step();
        run(100);
        check("t4_slip2", 32'(sl_m), 32'h222);
        check("t4_locked", 32'(lk_m), 32'h7);
        slip_req_m = 3'b111;
        step();
        run(5);
        check("t4_req_ignored", 32'(sl_m), 32'h222);
        tok_en = 1'b0;
        run(70);
        check("t4_unlock", 32'(lk_m), 32'h0);
        check("t4_slip_held", 32'(sl_m), 32'h222);
        slip_req_m = 3'b111;
        step();
        check("t4_slip3", 32'(sl_m), 32'h333);
        tok_en = 1'b1;
        // 5: tokens exactly on the expiry cycle -> counted as hits, no slip
        set_rot(0, 0, 0);
        tok_period = 64;
        do_reset();
        run(300);
        check("t5_slip", 32'(sl_a), 32'h000);
        check("t5_locked", 32'(lk_a), 32'h7);
        check("t5_locked_m", 32'(lk_m), 32'h7);
        // 6: in_valid glitch while locked, then relock
        tok_period = 16;
        run(20);
        in_valid = 1'b0;
        step();
        check("t6_drop_lock", 32'(lk_a), 32'h0);
        check("t6_drop_ctrl", 32'(oc_a), 32'h0);
        check("t6_slip_held", 32'(sl_a), 32'h000);
        in_valid = 1'b1;
        run(100);
        check("t6_relock", 32'(lk_a), 32'h7);
        // reset in the middle of hunting
        set_rot(7, 7, 7);
        do_reset();
        run(100);
        check("t6_hunt_slip", 32'(sl_a), 32'h111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_data", 32'(od_a), 32'h0);
        check("t6_rst_ctrl", 32'(oc_a), 32'h0);
        check("t6_rst_all", 32'(al_a), 32'h0);
        check("t6_rst_slip", 32'(sl_a), 32'h0);
        // randomized traffic: random rotations, token spacing, slip requests and valid drops
        for (int r = 0; r < 3; r++) begin
            set_rot(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            tok_period = int'($urandom_range(8, 40));
            do_reset();
            for (int n = 0; n < 700; n++) begin
                in_valid = $urandom_range(0, 99) != 0;
                for (int c = 0; c < NC; c++) begin
                    slip_req_a[c] = $urandom_range(0, 49) == 0;
                    slip_req_m[c] = $urandom_range(0, 29) == 0;
                end
                step();
            end
            in_valid = 1'b1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
